// File: rtl/match_or_inv_lock.sv
// rtl/match_or_inv_lock.sv - polarity-aware training-pattern lock detector (optional MATCH_OR_INV_ERR_CNT_EN miss counter)
module match_or_inv_lock #(
  parameter int WIDTH      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int MISS_LIMIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] pattern,
  output logic             match,
  output logic             inv,
  output logic             locked,
  output logic             polarity,
  output logic [15:0]      err_count
);

  // Thresholds as 8-bit values so counter compares are width-matched.
  localparam logic [7:0] LOCK_CNT8 = 8'(LOCK_COUNT);
  localparam logic [7:0] MISS_LIM8 = 8'(MISS_LIMIT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t     state, state_n;
  logic       pol, pol_n;
  logic [7:0] hit_cnt, hit_cnt_n;
  logic [7:0] miss_cnt, miss_cnt_n;
  logic       v1;
  logic       eq, eqn;
  logic       hit, hpol, same_hit;

  // Both comparisons are against the quasi-static pattern; they are exclusive.
  assign eq  = (din == pattern);
  assign eqn = (din == ~pattern);

  // Stage 1: register compare results for valid words; hold them across gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      match <= 1'b0;
      inv   <= 1'b0;
      v1    <= 1'b0;
    end else begin
      v1 <= din_valid;
      if (din_valid) begin
        match <= eq;
        inv   <= eqn;
      end
    end
  end

  assign hit      = match | inv;
  assign hpol     = inv;
  assign same_hit = hit && (hpol == pol);

  // Stage 2 state register: lock FSM with its polarity and run counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HUNT;
      pol      <= 1'b0;
      hit_cnt  <= 8'd0;
      miss_cnt <= 8'd0;
    end else begin
      state    <= state_n;
      pol      <= pol_n;
      hit_cnt  <= hit_cnt_n;
      miss_cnt <= miss_cnt_n;
    end
  end

  // Next-state logic: advances only when a compared word is waiting in stage 1.
  always_comb begin
    state_n    = state;
    pol_n      = pol;
    hit_cnt_n  = hit_cnt;
    miss_cnt_n = miss_cnt;
    if (v1) begin
      case (state)
        ST_HUNT: begin
          if (hit) begin
            pol_n     = hpol;
            hit_cnt_n = 8'd1;
            if (LOCK_CNT8 == 8'd1) begin
              state_n    = ST_LOCKED;
              miss_cnt_n = 8'd0;
            end else begin
              state_n = ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (same_hit) begin
            hit_cnt_n = hit_cnt + 8'd1;
            if (hit_cnt_n == LOCK_CNT8) begin
              state_n    = ST_LOCKED;
              miss_cnt_n = 8'd0;
            end
          end else if (hit) begin
            // Opposite polarity: start a fresh run in the new polarity.
            pol_n     = hpol;
            hit_cnt_n = 8'd1;
          end else begin
            state_n   = ST_HUNT;
            hit_cnt_n = 8'd0;
          end
        end
        ST_LOCKED: begin
          if (same_hit) begin
            miss_cnt_n = 8'd0;
          end else begin
            miss_cnt_n = miss_cnt + 8'd1;
            if (miss_cnt_n == MISS_LIM8) begin
              state_n    = ST_HUNT;
              hit_cnt_n  = 8'd0;
              miss_cnt_n = 8'd0;
            end
          end
        end
        default: begin
          state_n    = ST_HUNT;
          hit_cnt_n  = 8'd0;
          miss_cnt_n = 8'd0;
        end
      endcase
    end
  end

  assign locked   = (state == ST_LOCKED);
  assign polarity = locked & pol;

`ifdef MATCH_OR_INV_ERR_CNT_EN
  logic        err_inc;
  logic [15:0] err_q;

  // Every miss consumed while locked counts, including the one that drops lock.
  assign err_inc = v1 && (state == ST_LOCKED) && !same_hit;

  // Saturating error counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 16'h0000;
    end else if (err_inc && (err_q != 16'hFFFF)) begin
      err_q <= err_q + 16'h0001;
    end
  end

  assign err_count = err_q;
`else
  assign err_count = 16'h0000;
`endif

endmodule
